// File: rtl/periph_port_arbiter.sv
// periph_port_arbiter: packet arbiter sharing one Hermes port between two peripherals (TX grant, RX steering).
// Define PERIPH_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module periph_port_arbiter #(
  parameter int FLIT_SIZE = 32,
  parameter int ID_BIT    = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 release_i,
  input  logic                 src0_tx_i,
  output logic                 src0_credit_o,
  input  logic [FLIT_SIZE-1:0] src0_data_i,
  input  logic                 src1_tx_i,
  output logic                 src1_credit_o,
  input  logic [FLIT_SIZE-1:0] src1_data_i,
  output logic                 noc_tx_o,
  input  logic                 noc_credit_i,
  output logic [FLIT_SIZE-1:0] noc_data_o,
  input  logic                 noc_rx_i,
  output logic                 noc_credit_o,
  input  logic [FLIT_SIZE-1:0] noc_data_i,
  output logic                 dst0_tx_o,
  input  logic                 dst0_credit_i,
  output logic [FLIT_SIZE-1:0] dst0_data_o,
  output logic                 dst1_tx_o,
  input  logic                 dst1_credit_i,
  output logic [FLIT_SIZE-1:0] dst1_data_o,
  output logic [1:0]           tx_grant_o
);
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_SIZE, T_PAY} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_SIZE, R_PAY} rx_state_e;
  localparam logic [FLIT_SIZE-1:0] ONE = 1;
  tx_state_e t_q, t_d;
  rx_state_e r_q, r_d;
  logic own_q, own_d, dst_q, dst_d;
  logic [FLIT_SIZE-1:0] tcnt_q, tcnt_d, rcnt_q, rcnt_d;
  logic e0, e1, win, owned, t_xfer, tx_done, r_sel, r_ok, r_xfer;
  assign e0 = src0_tx_i;
  assign e1 = src1_tx_i & release_i;
`ifdef PERIPH_ARB_FIXED_PRIO_EN
  assign win = ~e0;
`else
  logic rr_q, rr_d;
  assign win  = (e0 & e1) ? rr_q : e1;
  assign rr_d = tx_done ? ~own_q : rr_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rr_q <= 1'b0;
    else         rr_q <= rr_d;
`endif
  assign owned         = t_q != T_IDLE;
  assign noc_tx_o      = owned & (own_q ? src1_tx_i : src0_tx_i);
  assign noc_data_o    = owned ? (own_q ? src1_data_i : src0_data_i) : '0;
  assign src0_credit_o = owned & ~own_q & noc_credit_i;
  assign src1_credit_o = owned & own_q & noc_credit_i;
  assign tx_grant_o    = {owned & own_q, owned & ~own_q};
  assign t_xfer        = noc_tx_o & noc_credit_i;
  always_comb begin
    t_d     = t_q;
    own_d   = own_q;
    tcnt_d  = tcnt_q;
    tx_done = 1'b0;
    case (t_q)
      T_IDLE: if (e0 | e1) begin
        t_d   = T_HDR;
        own_d = win;
      end
      T_HDR: if (t_xfer) t_d = T_SIZE;
      T_SIZE: if (t_xfer) begin
        tcnt_d  = noc_data_o;
        tx_done = noc_data_o == '0;
        t_d     = tx_done ? T_IDLE : T_PAY;
      end
      default: if (t_xfer) begin
        tcnt_d  = tcnt_q - ONE;
        tx_done = tcnt_q == ONE;
        t_d     = tx_done ? T_IDLE : T_PAY;
      end
    endcase
  end
  // Outputs are forced low while reset is held, since the RX path is combinational from the router.
  assign r_sel        = (r_q == R_IDLE) ? noc_data_i[ID_BIT] : dst_q;
  assign r_ok         = rst_ni & (~r_sel | release_i | (r_q != R_IDLE));
  assign dst0_tx_o    = r_ok & noc_rx_i & ~r_sel;
  assign dst1_tx_o    = r_ok & noc_rx_i & r_sel;
  assign noc_credit_o = r_ok & (r_sel ? dst1_credit_i : dst0_credit_i);
  assign dst0_data_o  = dst0_tx_o ? noc_data_i : '0;
  assign dst1_data_o  = dst1_tx_o ? noc_data_i : '0;
  assign r_xfer       = noc_rx_i & noc_credit_o;
  always_comb begin
    r_d    = r_q;
    dst_d  = dst_q;
    rcnt_d = rcnt_q;
    case (r_q)
      R_IDLE: if (r_xfer) begin
        r_d   = R_SIZE;
        dst_d = r_sel;
      end
      R_SIZE: if (r_xfer) begin
        rcnt_d = noc_data_i;
        r_d    = (noc_data_i == '0) ? R_IDLE : R_PAY;
      end
      default: if (r_xfer) begin
        rcnt_d = rcnt_q - ONE;
        r_d    = (rcnt_q == ONE) ? R_IDLE : R_PAY;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      t_q    <= T_IDLE;
      own_q  <= 1'b0;
      tcnt_q <= '0;
      r_q    <= R_IDLE;
      dst_q  <= 1'b0;
      rcnt_q <= '0;
    end else begin
      t_q    <= t_d;
      own_q  <= own_d;
      tcnt_q <= tcnt_d;
      r_q    <= r_d;
      dst_q  <= dst_d;
      rcnt_q <= rcnt_d;
    end
endmodule

// File: tb/tb_periph_port_arbiter.sv
// tb_periph_port_arbiter: directed vectors with hand-computed expectations for periph_port_arbiter.
module tb_periph_port_arbiter;
  logic clk_i = 0, rst_ni = 0, release_i = 0;
  logic src0_tx_i = 0, src1_tx_i = 0, noc_credit_i = 1, noc_rx_i = 0;
  logic dst0_credit_i = 1, dst1_credit_i = 1;
  logic [31:0] src0_data_i = 0, src1_data_i = 0, noc_data_i = 0;
  logic src0_credit_o, src1_credit_o, noc_tx_o, noc_credit_o, dst0_tx_o, dst1_tx_o;
  logic [31:0] noc_data_o, dst0_data_o, dst1_data_o;
  logic [1:0] tx_grant_o;
  int n_checks = 0, n_fails = 0;
  logic [31:0] flits [0:7];
  logic [31:0] p0 [0:2];
  logic [31:0] p1 [0:2];

  periph_port_arbiter #(.FLIT_SIZE(32), .ID_BIT(28)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .release_i(release_i),
    .src0_tx_i(src0_tx_i), .src0_credit_o(src0_credit_o), .src0_data_i(src0_data_i),
    .src1_tx_i(src1_tx_i), .src1_credit_o(src1_credit_o), .src1_data_i(src1_data_i),
    .noc_tx_o(noc_tx_o), .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
    .noc_rx_i(noc_rx_i), .noc_credit_o(noc_credit_o), .noc_data_i(noc_data_i),
    .dst0_tx_o(dst0_tx_o), .dst0_credit_i(dst0_credit_i), .dst0_data_o(dst0_data_o),
    .dst1_tx_o(dst1_tx_o), .dst1_credit_i(dst1_credit_i), .dst1_data_o(dst1_data_o),
    .tx_grant_o(tx_grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Drives n flits of flits[] from source s, starting in the header-owned state.
  task automatic send_tx(input bit s, input logic [1:0] g, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) release_i = 0;
      if (s) begin src1_tx_i = 1; src1_data_i = flits[i]; end
      else   begin src0_tx_i = 1; src0_data_i = flits[i]; end
      #1;
      check("tx_valid", {31'b0, noc_tx_o}, 32'd1);
      check("tx_data", noc_data_o, flits[i]);
      check("tx_grant", {30'b0, tx_grant_o}, {30'b0, g});
      check("tx_owner_credit", {31'b0, s ? src1_credit_o : src0_credit_o}, 32'd1);
      check("tx_other_credit", {31'b0, s ? src0_credit_o : src1_credit_o}, 32'd0);
      tick;
    end
    if (s) src1_tx_i = 0;
    else   src0_tx_i = 0;
  endtask

  initial begin
    int i0, i1, k, ph, idx;
    logic own, a0, a1;
    // Reset with live inputs: every output must stay low
    release_i = 1; noc_rx_i = 1; noc_data_i = 32'h1000_0000; src0_tx_i = 1;
    #2;
    check("rst_grant", {30'b0, tx_grant_o}, 32'd0);
    check("rst_noc_tx", {31'b0, noc_tx_o}, 32'd0);
    check("rst_src0_credit", {31'b0, src0_credit_o}, 32'd0);
    check("rst_noc_credit", {31'b0, noc_credit_o}, 32'd0);
    check("rst_dst1_tx", {31'b0, dst1_tx_o}, 32'd0);
    check("rst_dst1_data", dst1_data_o, 32'd0);
    tick;
    tick;
    rst_ni = 1; src0_tx_i = 0; noc_rx_i = 0; noc_data_i = 0;
    tick;

    // Single packet from src0
    flits[0] = 32'h8000_0100; flits[1] = 3; flits[2] = 32'hA; flits[3] = 32'hB; flits[4] = 32'hC;
    src0_tx_i = 1; src0_data_i = flits[0];
    #1;
    check("sp_idle_grant", {30'b0, tx_grant_o}, 32'd0);
    check("sp_idle_tx", {31'b0, noc_tx_o}, 32'd0);
    tick;
    send_tx(0, 2'b01, 5, -1);
    #1;
    check("sp_done_grant", {30'b0, tx_grant_o}, 32'd0);
    check("sp_done_tx", {31'b0, noc_tx_o}, 32'd0);
    tick;

    // Contention with size-1 packets; pointer now prefers src1
    p0[0] = 32'h0000_0A00; p0[1] = 1; p0[2] = 32'h0000_A0A0;
    p1[0] = 32'h1000_0B00; p1[1] = 1; p1[2] = 32'h0000_B1B1;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 16; c++) begin
      src0_tx_i = 1; src1_tx_i = 1;
      src0_data_i = p0[i0 % 3]; src1_data_i = p1[i1 % 3];
      #1;
      k = c / 4; ph = c % 4;
`ifdef PERIPH_ARB_FIXED_PRIO_EN
      own = 0;
`else
      own = (k % 2 == 0);
`endif
      if (ph == 0) check("ct_gap_grant", {30'b0, tx_grant_o}, 32'd0);
      else begin
        check("ct_grant", {30'b0, tx_grant_o}, own ? 32'd2 : 32'd1);
        check("ct_data", noc_data_o, own ? p1[ph-1] : p0[ph-1]);
      end
      a0 = src0_credit_o; a1 = src1_credit_o;
      tick;
      if (a0) i0++;
      if (a1) i1++;
    end
    src0_tx_i = 0; src1_tx_i = 0;
    tick;

    // Release gating on requester 1
    release_i = 0; src1_tx_i = 1; src1_data_i = 32'h1000_0C00;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rl_blocked_grant", {30'b0, tx_grant_o}, 32'd0);
      check("rl_blocked_credit", {31'b0, src1_credit_o}, 32'd0);
      tick;
    end
    release_i = 1;
    #1;
    check("rl_arb_grant", {30'b0, tx_grant_o}, 32'd0);
    tick;
    flits[0] = 32'h1000_0C00; flits[1] = 2; flits[2] = 32'h5555; flits[3] = 32'h6666;
    send_tx(1, 2'b10, 4, 3);
    #1;
    check("rl_done_grant", {30'b0, tx_grant_o}, 32'd0);
    release_i = 1;
    tick;

    // TX backpressure: credit toggles, size-4 packet
    flits[0] = 32'h8000_0300; flits[1] = 4;
    flits[2] = 32'hD1; flits[3] = 32'hD2; flits[4] = 32'hD3; flits[5] = 32'hD4;
    src0_tx_i = 1; src0_data_i = flits[0];
    tick;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      noc_credit_i = c[0];
      src0_data_i = flits[idx];
      #1;
      check("bp_data", noc_data_o, flits[idx]);
      check("bp_grant", {30'b0, tx_grant_o}, 32'd1);
      check("bp_credit", {31'b0, src0_credit_o}, {31'b0, c[0]});
      tick;
      if (c[0]) idx++;
    end
    src0_tx_i = 0; noc_credit_i = 1;
    #1;
    check("bp_done_grant", {30'b0, tx_grant_o}, 32'd0);
    tick;

    // RX steering to dst1, size 2, with a destination stall in the size flit
    noc_rx_i = 1; noc_data_i = 32'h1000_0005;
    #1;
    check("rx1_hdr_dst1", {31'b0, dst1_tx_o}, 32'd1);
    check("rx1_hdr_dst0", {31'b0, dst0_tx_o}, 32'd0);
    check("rx1_hdr_credit", {31'b0, noc_credit_o}, 32'd1);
    check("rx1_hdr_data", dst1_data_o, 32'h1000_0005);
    tick;
    noc_data_i = 2; dst1_credit_i = 0;
    #1;
    check("rx1_stall_credit", {31'b0, noc_credit_o}, 32'd0);
    tick;
    dst1_credit_i = 1;
    #1;
    check("rx1_size_dst1", {31'b0, dst1_tx_o}, 32'd1);
    check("rx1_size_credit", {31'b0, noc_credit_o}, 32'd1);
    tick;
    for (int c = 0; c < 2; c++) begin
      noc_data_i = 32'hC0DE_0001 + c;
      #1;
      check("rx1_pay_dst1", {31'b0, dst1_tx_o}, 32'd1);
      check("rx1_pay_dst0", {31'b0, dst0_tx_o}, 32'd0);
      check("rx1_pay_data", dst1_data_o, 32'hC0DE_0001 + c);
      tick;
    end
    // Next header straight after the last payload, to dst0, size 0
    noc_data_i = 32'h0000_0007;
    #1;
    check("rx0_hdr_dst0", {31'b0, dst0_tx_o}, 32'd1);
    check("rx0_hdr_dst1", {31'b0, dst1_tx_o}, 32'd0);
    check("rx0_hdr_data", dst0_data_o, 32'h0000_0007);
    tick;
    noc_data_i = 0;
    #1;
    check("rx0_size_dst0", {31'b0, dst0_tx_o}, 32'd1);
    tick;
    // Header to dst1 held while release is low
    noc_data_i = 32'h1000_0009; release_i = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rxg_credit", {31'b0, noc_credit_o}, 32'd0);
      check("rxg_dst1", {31'b0, dst1_tx_o}, 32'd0);
      tick;
    end
    release_i = 1;
    #1;
    check("rxg_rel_credit", {31'b0, noc_credit_o}, 32'd1);
    check("rxg_rel_dst1", {31'b0, dst1_tx_o}, 32'd1);
    tick;
    noc_data_i = 0;
    #1;
    check("rxg_size_dst1", {31'b0, dst1_tx_o}, 32'd1);
    tick;
    noc_rx_i = 0;
    tick;

    // Reset in the middle of concurrent TX and RX packets
    src0_tx_i = 1; src0_data_i = 32'h8000_0400; noc_rx_i = 1; noc_data_i = 32'h0000_0001;
    tick;
    noc_data_i = 4;
    #1;
    check("mr_grant", {30'b0, tx_grant_o}, 32'd1);
    tick;
    src0_data_i = 4;         noc_data_i = 32'hE1; tick;
    src0_data_i = 32'hF1;    noc_data_i = 32'hE2; tick;
    src0_data_i = 32'hF2;    noc_data_i = 32'hE3; tick;
    src0_data_i = 32'hF3;    noc_data_i = 32'hE4;
    rst_ni = 0;
    #1;
    check("mr_grant0", {30'b0, tx_grant_o}, 32'd0);
    check("mr_noc_tx0", {31'b0, noc_tx_o}, 32'd0);
    check("mr_noc_data0", noc_data_o, 32'd0);
    check("mr_src0_credit0", {31'b0, src0_credit_o}, 32'd0);
    check("mr_noc_credit0", {31'b0, noc_credit_o}, 32'd0);
    check("mr_dst0_tx0", {31'b0, dst0_tx_o}, 32'd0);
    check("mr_dst0_data0", dst0_data_o, 32'd0);
    tick;
    rst_ni = 1; src0_data_i = 32'h8000_0200; noc_data_i = 32'h1000_0003;
    #1;
    check("mr_post_grant_idle", {30'b0, tx_grant_o}, 32'd0);
    check("mr_post_rx_hdr", {31'b0, dst1_tx_o}, 32'd1);
    tick;
    noc_data_i = 0;
    #1;
    check("mr_post_grant", {30'b0, tx_grant_o}, 32'd1);
    check("mr_post_data", noc_data_o, 32'h8000_0200);
    tick;
    src0_data_i = 0; noc_rx_i = 0;
    tick;
    src0_tx_i = 0;
    #1;
    check("mr_post_done", {30'b0, tx_grant_o}, 32'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/periph_port_arbiter.md
# periph_port_arbiter

Packet-level arbiter that shares one Hermes boundary port of an edge PE between two peripherals, such as the MA injector and the App injector. It sits between the peripherals and the router port.
- **TX (peripherals to NoC):** grants the port to one peripheral for a whole packet (header, size, payload).
- **RX (NoC to peripherals):** steers each incoming packet to one peripheral by a header bit.
- **Gating:** requester 1 is controlled by the PE's release-peripheral signal.

## Interface
Parameters:
- `FLIT_SIZE`, 32: flit and data width; also the width of the payload counters.
- `ID_BIT`, 28: bit of the RX header flit that selects the destination (0 → dst0, 1 → dst1).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `release_i` in 1: requester/destination 1 enabled.
- `src0_tx_i` in 1, `src0_credit_o` out 1, `src0_data_i` in `FLIT_SIZE`: peripheral 0 TX.
- `src1_tx_i` in 1, `src1_credit_o` out 1, `src1_data_i` in `FLIT_SIZE`: peripheral 1 TX.
- `noc_tx_o` out 1, `noc_credit_i` in 1, `noc_data_o` out `FLIT_SIZE`: towards router.
- `noc_rx_i` in 1, `noc_credit_o` out 1, `noc_data_i` in `FLIT_SIZE`: from router.
- `dst0_tx_o` out 1, `dst0_credit_i` in 1, `dst0_data_o` out `FLIT_SIZE`: to peripheral 0.
- `dst1_tx_o` out 1, `dst1_credit_i` in 1, `dst1_data_o` out `FLIT_SIZE`: to peripheral 1.
- `tx_grant_o` out 2: one-hot current TX owner; 00 when idle.

## Operation
- **Handshake:** a flit transfers on any link when tx and credit are both high in the same cycle.
- **TX FSM states:** T_IDLE, T_HDR, T_SIZE, T_PAY.
- **T_IDLE:**
  - Requester 0 is eligible if `src0_tx_i`.
  - Requester 1 is eligible if `src1_tx_i && release_i`.
  - Winner is chosen by round-robin: a 1-bit pointer names the preferred requester.
  - If any requester is eligible, register the winner and go to T_HDR.
- **Owned states (T_HDR, T_SIZE, T_PAY):**
  - `noc_tx_o` and `noc_data_o` mux the owner's tx/data.
  - Owner's credit equals `noc_credit_i`; the other requester's credit is 0.
- **T_HDR:** on transfer, go to T_SIZE.
- **T_SIZE:** on transfer, load the counter with the data value.
  - Value 0: go to T_IDLE.
  - Otherwise: go to T_PAY.
- **T_PAY:** each transfer decrements the counter; the transfer at count 1 returns to T_IDLE.
- **Round-robin update:** on return to T_IDLE, the pointer moves to the non-owner.
- **Release during a packet:** the grant is never revoked mid-packet; `release_i` is sampled only at arbitration.
- **RX FSM states:** R_IDLE, R_SIZE, R_PAY.
- **R_IDLE:**
  - Destination is `noc_data_i[ID_BIT]`, decoded combinationally and forwarded to that `dst`.
  - `noc_credit_o` = selected destination's credit.
  - If the destination is 1 and `release_i` is 0, `dst1_tx_o`=0 and `noc_credit_o`=0, so the header is held.
  - On header transfer, latch the destination and go to R_SIZE.
- **R_SIZE / R_PAY:** same counting as TX, forwarded to the latched destination; the non-selected `dst_tx` is 0.
- **Concurrency:** TX and RX are fully independent and may run concurrently.
- **Data outputs:** outputs with tx low carry the don't-care mux value; no requirement.

## Timing
- **Reset values:** all outputs 0 (tx, credit, data, `tx_grant_o`), states IDLE, counters 0, RR pointer = 0.
- **TX latency:** one-cycle arbitration bubble (T_IDLE→T_HDR). Afterwards, one flit per cycle while `noc_credit_i`=1.
- **TX back-to-back:** packets are separated by exactly one idle cycle.
- **RX latency:** zero-latency combinational path and no bubble. A header may transfer in the cycle after the previous last payload flit.
- **Backpressure:** credit low stalls without loss; the state holds and the counter is unchanged.
- **Counter width:** `FLIT_SIZE` bits; a size of 2^`FLIT_SIZE`−1 is legal.
- **Reset mid-packet:** asserting `rst_ni` low immediately forces IDLE; the partial packet is dropped.

## Configuration
- **`PERIPH_ARB_FIXED_PRIO_EN`:**
  - Defined: requester 0 always wins when eligible and the RR pointer is not implemented.
  - Undefined: round-robin as above.

## Test plan
- **Single packet:** `src0` sends header 0x80000100, size 3, payload A,B,C with `noc_credit_i`=1 → `tx_grant_o`=01 one cycle later; 5 flits on NoC in 5 consecutive cycles; grant 00 after.
- **Contention:** both sources request continuously with size-1 packets → grants alternate 01,10,01,10, with one idle cycle between packets. With `PERIPH_ARB_FIXED_PRIO_EN` → always 01.
- **Release gating:** `release_i`=0 and only `src1` requests → no grant, `src1_credit_o`=0. Raise `release_i` → grant 10 next cycle. Drop `release_i` mid-payload → packet completes.
- **RX steering:** header with bit 28=1, size 2 → both payload flits appear only on `dst1`. Header with bit 28=0 → `dst0`. Header to dst1 with `release_i`=0 → `noc_credit_o`=0 until release.
- **Backpressure:** toggle `noc_credit_i` every cycle during a size-4 packet → all 6 flits delivered in order, none duplicated.
- **Reset mid-packet:** assert `rst_ni` after 2 payload flits → all outputs 0 at once; the next packet after reset arbitrates normally.
